// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter feeding a UART TX FIFO; ties go to the requester that did not own last.
// Define UART_ARB_TIMEOUT_EN to enable the mid-packet idle-timeout forced release.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic [7:0]  uart_data,
  output logic        uart_wren,
  input  logic        uart_full,
  output logic [1:0]  grant,
  output logic [15:0] pkt_count,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BUSY0 = 2'b01;
  localparam logic [1:0] BUSY1 = 2'b10;

  logic [1:0] state;
  logic       rr_last;
  logic       acc0;
  logic       acc1;
  logic       own_last;
  logic       pkt_done;
  logic       tmo_fire;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  assign grant      = {state == BUSY1, state == BUSY0};
  assign req0_ready = grant[0] & ~uart_full;
  assign req1_ready = grant[1] & ~uart_full;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign uart_wren  = acc0 | acc1;
  assign uart_data  = grant[0] ? req0_data : (grant[1] ? req1_data : '0);
  assign own_last   = grant[0] ? req0_last : req1_last;
  assign pkt_done   = uart_wren & own_last;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && (!req1_valid || rr_last)) state <= BUSY0;
          else if (req1_valid)                        state <= BUSY1;
        end
        BUSY0, BUSY1: begin
          // Both normal completion and forced release hand priority to the other requester.
          if (pkt_done || tmo_fire) begin
            state   <= IDLE;
            rr_last <= grant[1];
          end
          if (pkt_done) pkt_count <= pkt_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd2);

  logic [15:0] idle_cnt;
  logic        own_valid;
  logic        idle_cyc;

  assign own_valid = grant[0] ? req0_valid : req1_valid;
  assign idle_cyc  = (state != IDLE) && !own_valid && !uart_full;
  // Fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  assign tmo_fire  = idle_cyc && (idle_cnt == TMO_LAST);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      if (state == IDLE || uart_wren || tmo_fire) idle_cnt <= '0;
      else if (idle_cyc)                          idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; timeout scenario depends on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [7:0]  req0_data, req1_data, uart_data;
  logic        uart_wren, uart_full, timeout_err;
  logic [1:0]  grant;
  logic [15:0] pkt_count;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] exp_pkt;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .uart_data(uart_data), .uart_wren(uart_wren), .uart_full(uart_full),
    .grant(grant), .pkt_count(pkt_count), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge so inputs can be driven.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h22; req1_last = 1'b0;
    uart_full  = 1'b0;
    @(negedge CLK); @(negedge CLK);
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    vectors++; if (uart_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", uart_wren); end
    vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    vectors++; if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", uart_data); end
    vectors++; if (pkt_count !== 16'h0000) begin errors++; $display("FAIL reset_pkt: got %h expected 0000", pkt_count); end
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b expected 0", timeout_err); end
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_pkt = 16'd0;
  endtask

  task automatic test_single_packet;
    logic [7:0] bytes [3];
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    step; req0_valid = 1'b1; req0_data = 8'h41; req0_last = 1'b0;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle_grant: got %b expected 00", grant); end
    vectors++; if (uart_wren !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL single_idle_wren: got %b/%b expected 0/0", uart_wren, req0_ready); end
    for (int i = 0; i < 3; i++) begin
      step; req0_data = bytes[i]; req0_last = (i == 2);
      @(negedge CLK);
      vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant[%0d]: got %b expected 01", i, grant); end
      vectors++; if (uart_wren !== 1'b1) begin errors++; $display("FAIL single_wren[%0d]: got %b expected 1", i, uart_wren); end
      vectors++; if (uart_data !== bytes[i]) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", i, uart_data, bytes[i]); end
    end
    step; req0_valid = 1'b0; req0_last = 1'b0;
    exp_pkt = exp_pkt + 16'd1;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", grant); end
    vectors++; if (pkt_count !== exp_pkt) begin errors++; $display("FAIL single_pkt: got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g [9];
    logic [7:0] exp_d [9];
    logic idx0, idx1;
    exp_g[0] = 2'b00; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b00; exp_g[4] = 2'b10;
    exp_g[5] = 2'b10; exp_g[6] = 2'b00; exp_g[7] = 2'b01; exp_g[8] = 2'b01;
    exp_d[0] = 8'h00; exp_d[1] = 8'hA0; exp_d[2] = 8'hA1; exp_d[3] = 8'h00; exp_d[4] = 8'hB0;
    exp_d[5] = 8'hB1; exp_d[6] = 8'h00; exp_d[7] = 8'hA0; exp_d[8] = 8'hA1;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    exp_pkt = 16'd0;
    idx0 = 1'b0; idx1 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      step;
      req0_valid = 1'b1; req0_data = 8'hA0 + {7'd0, idx0}; req0_last = idx0;
      req1_valid = 1'b1; req1_data = 8'hB0 + {7'd0, idx1}; req1_last = idx1;
      @(negedge CLK);
      vectors++; if (grant !== exp_g[c]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, grant, exp_g[c]); end
      vectors++; if (uart_wren !== (exp_g[c] != 2'b00)) begin errors++; $display("FAIL rr_wren[%0d]: got %b expected %b", c, uart_wren, exp_g[c] != 2'b00); end
      vectors++; if (uart_data !== exp_d[c]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", c, uart_data, exp_d[c]); end
      if (exp_g[c] == 2'b01) idx0 = ~idx0;
      if (exp_g[c] == 2'b10) idx1 = ~idx1;
    end
    step; req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
    exp_pkt = 16'd3;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_release: got %b expected 00", grant); end
    vectors++; if (pkt_count !== exp_pkt) begin errors++; $display("FAIL rr_pkt: got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_full_stall;
    step; req1_valid = 1'b1; req1_data = 8'hC0; req1_last = 1'b0;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL stall_idle: got %b expected 00", grant); end
    step;
    @(negedge CLK);
    vectors++; if (uart_wren !== 1'b1 || uart_data !== 8'hC0) begin errors++; $display("FAIL stall_first: got %b/%h expected 1/c0", uart_wren, uart_data); end
    step; req1_data = 8'hC1; uart_full = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      vectors++; if ({req0_ready, req1_ready, uart_wren} !== 3'b000) begin errors++; $display("FAIL stall_hold[%0d]: ready0/ready1/wren got %b expected 000", k, {req0_ready, req1_ready, uart_wren}); end
      vectors++; if (grant !== 2'b10 || uart_data !== 8'hC1) begin errors++; $display("FAIL stall_grant[%0d]: got %b/%h expected 10/c1", k, grant, uart_data); end
      if (k < 9) step;
    end
    step; uart_full = 1'b0;
    @(negedge CLK);
    vectors++; if (uart_wren !== 1'b1 || uart_data !== 8'hC1 || req0_ready !== 1'b0) begin errors++; $display("FAIL stall_resume: wren/data/ready0 got %b/%h/%b expected 1/c1/0", uart_wren, uart_data, req0_ready); end
    step; req1_data = 8'hC2; req1_last = 1'b1;
    @(negedge CLK);
    vectors++; if (uart_wren !== 1'b1 || uart_data !== 8'hC2) begin errors++; $display("FAIL stall_last: got %b/%h expected 1/c2", uart_wren, uart_data); end
    step; req1_valid = 1'b0; req1_last = 1'b0; req0_valid = 1'b0; req0_last = 1'b0;
    exp_pkt = exp_pkt + 16'd1;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00 || pkt_count !== exp_pkt) begin errors++; $display("FAIL stall_release: grant/pkt got %b/%0d expected 00/%0d", grant, pkt_count, exp_pkt); end
  endtask

  task automatic test_timeout;
    step; req1_valid = 1'b1; req1_data = 8'hD0; req1_last = 1'b0;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL tmo_idle: got %b expected 00", grant); end
    step;
    @(negedge CLK);
    vectors++; if (uart_wren !== 1'b1 || uart_data !== 8'hD0 || grant !== 2'b10) begin errors++; $display("FAIL tmo_accept: got %b/%h/%b expected 1/d0/10", uart_wren, uart_data, grant); end
    step; req1_valid = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int j = 1; j <= 7; j++) begin
      @(negedge CLK);
      vectors++; if (grant !== 2'b10 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_wait[%0d]: grant/tmo got %b/%b expected 10/0", j, grant, timeout_err); end
      step;
    end
    @(negedge CLK);
    vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", timeout_err); end
    vectors++; if (grant !== 2'b00 || pkt_count !== exp_pkt) begin errors++; $display("FAIL tmo_release: grant/pkt got %b/%0d expected 00/%0d", grant, pkt_count, exp_pkt); end
    step;
    @(negedge CLK);
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle: got %b expected 0", timeout_err); end
`else
    for (int j = 1; j <= 20; j++) begin
      @(negedge CLK);
      vectors++; if (grant !== 2'b10 || timeout_err !== 1'b0) begin errors++; $display("FAIL hold_wait[%0d]: grant/tmo got %b/%b expected 10/0", j, grant, timeout_err); end
      step;
    end
    req1_valid = 1'b1; req1_data = 8'hD1; req1_last = 1'b1;
    @(negedge CLK);
    vectors++; if (uart_wren !== 1'b1 || uart_data !== 8'hD1) begin errors++; $display("FAIL hold_last: got %b/%h expected 1/d1", uart_wren, uart_data); end
    step; req1_valid = 1'b0; req1_last = 1'b0;
    exp_pkt = exp_pkt + 16'd1;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00 || pkt_count !== exp_pkt) begin errors++; $display("FAIL hold_release: grant/pkt got %b/%0d expected 00/%0d", grant, pkt_count, exp_pkt); end
`endif
  endtask

  task automatic test_reset_mid_packet;
    step; req1_valid = 1'b1; req1_data = 8'hE0; req1_last = 1'b0;
    @(negedge CLK);
    step;
    @(negedge CLK);
    vectors++; if (grant !== 2'b10 || uart_data !== 8'hE0) begin errors++; $display("FAIL rstmid_b0: got %b/%h expected 10/e0", grant, uart_data); end
    step; req1_data = 8'hE1;
    @(negedge CLK);
    vectors++; if (uart_wren !== 1'b1 || uart_data !== 8'hE1) begin errors++; $display("FAIL rstmid_b1: got %b/%h expected 1/e1", uart_wren, uart_data); end
    step; req1_data = 8'hE2;
    req0_valid = 1'b1; req0_data = 8'hF0; req0_last = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant: got %b expected 00", grant); end
    vectors++; if ({uart_wren, req0_ready, req1_ready} !== 3'b000 || uart_data !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: wren/ready0/ready1 %b data %h expected 000 00", {uart_wren, req0_ready, req1_ready}, uart_data); end
    vectors++; if (pkt_count !== 16'h0000) begin errors++; $display("FAIL rstmid_pkt: got %0d expected 0", pkt_count); end
    @(negedge CLK); @(negedge CLK);
    rst_n = 1'b1;
    step;
    @(negedge CLK);
    vectors++; if (grant !== 2'b01 || uart_data !== 8'hF0) begin errors++; $display("FAIL rstmid_regrant: got %b/%h expected 01/f0", grant, uart_data); end
    step; req0_data = 8'hF1; req0_last = 1'b1;
    @(negedge CLK);
    step; req0_valid = 1'b0; req0_last = 1'b0; req1_valid = 1'b0;
    @(negedge CLK);
    vectors++; if (grant !== 2'b00 || pkt_count !== 16'd1) begin errors++; $display("FAIL rstmid_count: grant/pkt got %b/%0d expected 00/1", grant, pkt_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    uart_full = 1'b0;
    exp_pkt = '0;
    test_reset;
    test_single_packet;
    test_back_to_back;
    test_full_stall;
    test_timeout;
    test_reset_mid_packet;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, the mid-packet idle cycles before a forced grant release; legal range 2..65535.
REQ-002 SHALL have port CLK  input  1  the single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester has a byte.
REQ-005 SHALL have ports req0_data/req1_data  input  8 each  requester byte.
REQ-006 SHALL have ports req0_last/req1_last  input  1 each  byte is the final byte of its packet.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1 each  byte accepted this cycle when valid is also high.
REQ-008 SHALL have port uart_data  output  8  byte to the UART TX FIFO data_in.
REQ-009 SHALL have port uart_wren  output  1  write strobe to the UART TX FIFO.
REQ-010 SHALL have port uart_full  input  1  UART TX FIFO full flag.
REQ-011 SHALL have port grant  output  2  one-hot owner: bit0 is requester 0, bit1 is requester 1, 00 is none.
REQ-012 SHALL have port pkt_count  output  16  completed packets, wraps 0xFFFF->0x0000.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-014 SHALL implement states IDLE, BUSY0 and BUSY1; grant SHALL be 01 in BUSY0, 10 in BUSY1, and 00 in IDLE.
REQ-015 In IDLE, if exactly one req*_valid is high, SHALL enter that requester's BUSY state on the next edge.
REQ-016 In IDLE with both req*_valid high, SHALL grant the requester that is not rr_last, where rr_last is a 1-bit register holding the last released owner.
REQ-017 reqN_ready SHALL be grant[N] & ~uart_full, combinational; in IDLE no requester SHALL be ready.
REQ-018 uart_wren SHALL be the combinational accept of the owner (reqN_valid & reqN_ready); uart_data SHALL be the owner's reqN_data, and 0x00 when there is no owner.
REQ-019 Byte latency from accept to the FIFO write SHALL be zero cycles, so no write ever occurs while uart_full=1.
REQ-020 An accepted byte with reqN_last=1 SHALL, on the next edge: move to IDLE, set rr_last=N, and increment pkt_count.
REQ-021 After any release SHALL spend at least one cycle in IDLE before granting again.
REQ-022 The non-owner's valid, data and last SHALL be ignored; its ready SHALL stay 0.
REQ-023 A deasserted valid mid-packet SHALL keep the grant, subject to REQ-029.
REQ-024 A uart_full stall SHALL keep the grant indefinitely.

Reset
REQ-025 Asserting rst_n=0 SHALL, asynchronously and at any time including mid-packet, force: state=IDLE, grant=00, rr_last=1, pkt_count=0, timeout_err=0, idle counter=0.
REQ-026 During reset, uart_wren and both readys SHALL be 0 and uart_data SHALL be 0x00.
REQ-027 After rst_n deasserts, the first arbitration with both requesters valid SHALL grant requester 0.
REQ-028 A packet interrupted by reset SHALL NOT be counted and SHALL NOT be resumed.

Configuration
REQ-029 With UART_ARB_TIMEOUT_EN defined, in BUSYn a 16-bit idle counter SHALL:
- count cycles with reqN_valid=0 and uart_full=0;
- clear on any accept and on entering BUSY;
- on reaching TIMEOUT_CYCLES-1, force IDLE, set rr_last=N, pulse timeout_err for one cycle, and leave pkt_count unchanged.
REQ-030 Without UART_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and the grant SHALL persist until last.

Verification
REQ-031 Requester 0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, uart_full=0 -> grant=01 one cycle after valid; uart_wren high on 3 consecutive cycles with those bytes; IDLE next; pkt_count=1.
REQ-032 Both requesters valid out of reset, each sending 2-byte packets repeatedly -> grant sequence 01,00,10,00,01; bytes are never interleaved.
REQ-033 Mid-packet uart_full=1 for 10 cycles -> ready=0 and uart_wren=0 for those 10 cycles; grant holds; transfer resumes with the next byte.
REQ-034 UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, requester 1 sends one non-last byte then drops valid -> timeout_err pulses 8 cycles after the last accept; grant=00; pkt_count unchanged.
REQ-035 rst_n=0 pulsed during BUSY1 after 2 bytes -> grant=00 immediately; pkt_count=0; both requesters valid then -> grant=01.
